// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS receive definitions: block geometry, sync headers,
// descrambler taps and the block-lock state encoding.
package pcs_pkg;

   localparam int unsigned BLOCK_W   = 66;
   localparam int unsigned PAYLOAD_W = 64;
   localparam int unsigned TAP_A     = 39;
   localparam int unsigned TAP_B     = 58;
   localparam int unsigned BER_LIMIT = 16;

   localparam logic [1:0] SH_DATA = 2'b01;
   localparam logic [1:0] SH_CTRL = 2'b10;

   typedef enum logic [1:0] {
      RESET_CNT,
      TEST_SH,
      SLIP,
      SLIP_WAIT
   } lock_state_e;

   function automatic logic sh_valid(input logic [1:0] sh);
      return (sh == SH_DATA) || (sh == SH_CTRL);
   endfunction

endpackage

// File: rtl/block_lock_fsm.sv
// Sync-header block-lock state machine with gearbox slip request.
// Optional BER monitor built only when DESCRAMBLE_BER_MON_EN is defined.
module block_lock_fsm
   import pcs_pkg::*;
#(
   parameter int unsigned SH_WIN       = 64,
   parameter int unsigned SH_INVLD_MAX = 16,
   parameter int unsigned SLIP_WAIT    = 32,
   parameter int unsigned BER_WIN      = 19531
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [1:0] sh_i,
   input  logic       vld_i,
   output logic       block_lock_o,
   output logic       slip_o,
   output logic       hi_ber_o
);

   localparam int unsigned SH_CNT_W = $clog2(SH_WIN + 1);
   localparam int unsigned INV_W    = $clog2(SH_INVLD_MAX + 1);
   localparam int unsigned WAIT_W   = $clog2(SLIP_WAIT + 1);

   lock_state_e         r_state, w_state_d;
   logic [SH_CNT_W-1:0] r_sh_cnt, w_sh_cnt_d, w_sh_cnt_inc;
   logic [INV_W-1:0]    r_inv_cnt, w_inv_cnt_d, w_inv_cnt_inc;
   logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt_d, w_wait_cnt_inc;
   logic                r_lock, w_lock_d;
   logic                r_slip, w_slip_d;
   logic                w_sh_bad;

   assign w_sh_bad = !sh_valid(sh_i);

   assign w_sh_cnt_inc  = (r_sh_cnt == SH_CNT_W'(SH_WIN)) ? r_sh_cnt : r_sh_cnt + 1'b1;
   assign w_inv_cnt_inc = (w_sh_bad && (r_inv_cnt != INV_W'(SH_INVLD_MAX))) ?
                          r_inv_cnt + 1'b1 : r_inv_cnt;
   assign w_wait_cnt_inc = (r_wait_cnt == WAIT_W'(SLIP_WAIT)) ? r_wait_cnt : r_wait_cnt + 1'b1;

   always_comb begin
      w_state_d    = r_state;
      w_sh_cnt_d   = r_sh_cnt;
      w_inv_cnt_d  = r_inv_cnt;
      w_wait_cnt_d = r_wait_cnt;
      w_lock_d     = r_lock;
      w_slip_d     = 1'b0;
      unique case (r_state)
         RESET_CNT: begin
            w_sh_cnt_d  = '0;
            w_inv_cnt_d = '0;
            w_state_d   = TEST_SH;
         end
         TEST_SH: begin
            if (vld_i) begin
               w_sh_cnt_d  = w_sh_cnt_inc;
               w_inv_cnt_d = w_inv_cnt_inc;
               // Invalid-limit check precedes window completion so a tie slips.
               if (!r_lock && w_sh_bad) begin
                  w_state_d = SLIP;
               end else if (r_lock && (w_inv_cnt_inc >= INV_W'(SH_INVLD_MAX))) begin
                  w_state_d = SLIP;
               end else if (w_sh_cnt_inc >= SH_CNT_W'(SH_WIN)) begin
                  if (w_inv_cnt_inc == '0) w_lock_d = 1'b1;
                  w_state_d = RESET_CNT;
               end
            end
         end
         SLIP: begin
            w_wait_cnt_d = '0;
            w_state_d    = pcs_pkg::SLIP_WAIT;
         end
         pcs_pkg::SLIP_WAIT: begin
            if (vld_i) begin
               w_wait_cnt_d = w_wait_cnt_inc;
               if (w_wait_cnt_inc >= WAIT_W'(SLIP_WAIT)) w_state_d = RESET_CNT;
            end
         end
         default: w_state_d = RESET_CNT;
      endcase
      if (w_state_d == SLIP) begin
         w_slip_d = 1'b1;
         w_lock_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= RESET_CNT;
         r_sh_cnt   <= '0;
         r_inv_cnt  <= '0;
         r_wait_cnt <= '0;
         r_lock     <= 1'b0;
         r_slip     <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_sh_cnt   <= w_sh_cnt_d;
         r_inv_cnt  <= w_inv_cnt_d;
         r_wait_cnt <= w_wait_cnt_d;
         r_lock     <= w_lock_d;
         r_slip     <= w_slip_d;
      end
   end

   assign block_lock_o = r_lock;
   assign slip_o       = r_slip;

`ifdef DESCRAMBLE_BER_MON_EN
   localparam int unsigned BER_CNT_W = $clog2(BER_WIN + 1);
   localparam int unsigned BER_ERR_W = $clog2(BER_LIMIT + 1);

   logic [BER_CNT_W-1:0] r_ber_win, w_ber_win_inc;
   logic [BER_ERR_W-1:0] r_ber_err, w_ber_err_inc;
   logic                 r_hi_ber;

   assign w_ber_win_inc = r_ber_win + 1'b1;
   assign w_ber_err_inc = (w_sh_bad && (r_ber_err != BER_ERR_W'(BER_LIMIT))) ?
                          r_ber_err + 1'b1 : r_ber_err;

   // Flag sets mid-window; only the window boundary may clear it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_ber_win <= '0;
         r_ber_err <= '0;
         r_hi_ber  <= 1'b0;
      end else if (vld_i) begin
         if (w_ber_win_inc >= BER_CNT_W'(BER_WIN)) begin
            r_ber_win <= '0;
            r_ber_err <= '0;
            r_hi_ber  <= (w_ber_err_inc >= BER_ERR_W'(BER_LIMIT));
         end else begin
            r_ber_win <= w_ber_win_inc;
            r_ber_err <= w_ber_err_inc;
            if (w_ber_err_inc >= BER_ERR_W'(BER_LIMIT)) r_hi_ber <= 1'b1;
         end
      end
   end

   assign hi_ber_o = r_hi_ber;
`else
   logic w_ber_unused;
   assign w_ber_unused = (BER_WIN == 0);
   assign hi_ber_o     = 1'b0;
`endif

endmodule

// File: rtl/descramble_lock.sv
// 10GBASE-R receive descrambler (x^58 + x^39 + 1) with block-lock control.
// Define DESCRAMBLE_BER_MON_EN to build the high-BER monitor.
module descramble_lock
   import pcs_pkg::*;
#(
   parameter int unsigned SH_WIN       = 64,
   parameter int unsigned SH_INVLD_MAX = 16,
   parameter int unsigned SLIP_WAIT    = 32,
   parameter int unsigned BER_WIN      = 19531
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [BLOCK_W-1:0] data_i,
   input  logic               data_vld_i,
   output logic [BLOCK_W-1:0] data_o,
   output logic               data_vld_o,
   output logic               block_lock_o,
   output logic               slip_o,
   output logic               hi_ber_o
);

   logic [TAP_B-1:0]           r_hist, w_hist_d;
   logic [BLOCK_W-1:0]         r_data;
   logic                       r_vld;
   logic [PAYLOAD_W-1:0]       w_scr, w_plain;
   logic [PAYLOAD_W+TAP_B-1:0] w_ext;

   assign w_scr = data_i[BLOCK_W-1:2];

   // w_ext is the received stream from s[-58] upward, so tap offsets stay non-negative.
   always_comb begin
      w_ext    = {w_scr, {TAP_B{1'b0}}};
      w_hist_d = '0;
      w_plain  = '0;
      for (int k = 0; k < TAP_B; k++) begin
         w_ext[k]    = r_hist[TAP_B-1-k];
         w_hist_d[k] = w_scr[PAYLOAD_W-1-k];
      end
      for (int i = 0; i < PAYLOAD_W; i++) begin
         w_plain[i] = w_scr[i] ^ w_ext[i+TAP_B-TAP_A] ^ w_ext[i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_hist <= '0;
         r_data <= '0;
         r_vld  <= 1'b0;
      end else begin
         r_vld <= data_vld_i;
         if (data_vld_i) begin
            r_data <= {w_plain, data_i[1:0]};
            r_hist <= w_hist_d;
         end
      end
   end

   assign data_o     = r_data;
   assign data_vld_o = r_vld;

   block_lock_fsm #(
      .SH_WIN       (SH_WIN),
      .SH_INVLD_MAX (SH_INVLD_MAX),
      .SLIP_WAIT    (SLIP_WAIT),
      .BER_WIN      (BER_WIN)
   ) u_block_lock_fsm (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .sh_i         (data_i[1:0]),
      .vld_i        (data_vld_i),
      .block_lock_o (block_lock_o),
      .slip_o       (slip_o),
      .hi_ber_o     (hi_ber_o)
   );

endmodule

// File: tb/tb_descramble_lock.sv
// Directed bench for descramble_lock: descrambling, block lock, slips, reset
// and (with DESCRAMBLE_BER_MON_EN) the high-BER flag.
module tb_descramble_lock;

   localparam int unsigned SH_WIN       = 64;
   localparam int unsigned SH_INVLD_MAX = 16;
   localparam int unsigned SLIP_WAIT    = 32;
   localparam int unsigned BER_WIN      = 100;
   localparam int          NB           = 500;
   localparam int          STREAM_BITS  = 66 * NB + 8;

   typedef struct {
      logic [1:0]  hdr;
      logic [63:0] pay;
      logic        exp_lock;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [65:0] data_i;
   logic        data_vld_i;
   logic [65:0] data_o;
   logic        data_vld_o;
   logic        block_lock_o;
   logic        slip_o;
   logic        hi_ber_o;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [57:0] tx_st;
   logic        s_lock, s_slip, s_ber;
   logic        chk_ber;
   bit          stream [STREAM_BITS];

   always #5 clk = ~clk;

   descramble_lock #(
      .SH_WIN       (SH_WIN),
      .SH_INVLD_MAX (SH_INVLD_MAX),
      .SLIP_WAIT    (SLIP_WAIT),
      .BER_WIN      (BER_WIN)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .data_i       (data_i),
      .data_vld_i   (data_vld_i),
      .data_o       (data_o),
      .data_vld_o   (data_vld_o),
      .block_lock_o (block_lock_o),
      .slip_o       (slip_o),
      .hi_ber_o     (hi_ber_o)
   );

   task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {65'd0, act}, {65'd0, exp});
   endtask

   // Transmit scrambler: s[i] = d[i] ^ s[i-39] ^ s[i-58]; tx_st[0] is the newest bit.
   task automatic scramble(input logic [63:0] d, output logic [63:0] s);
      for (int i = 0; i < 64; i++) begin
         s[i]  = d[i] ^ tx_st[38] ^ tx_st[57];
         tx_st = {tx_st[56:0], s[i]};
      end
   endtask

   // One valid clock then one idle clock; data_o must hold across the idle one.
   task automatic send(input logic [65:0] blk, input logic [65:0] exp, input logic chk_out);
      @(negedge clk);
      data_i     = blk;
      data_vld_i = 1'b1;
      @(posedge clk);
      #1;
      s_lock = block_lock_o;
      s_slip = slip_o;
      s_ber  = hi_ber_o;
      chk1("vld_out", data_vld_o, 1'b1);
      if (chk_out) chk("data_out", data_o, exp);
      if (chk_ber) chk1("hi_ber_zero", hi_ber_o, 1'b0);
      @(negedge clk);
      data_vld_i = 1'b0;
      data_i     = ~blk;
      @(posedge clk);
      #1;
      chk1("vld_gap", data_vld_o, 1'b0);
      chk1("slip_gap", slip_o, 1'b0);
      if (chk_out) chk("data_hold", data_o, exp);
   endtask

   task automatic send_lb(input logic [1:0] hdr, input logic [63:0] pay, input logic chk_out);
      logic [63:0] sc;
      scramble(pay, sc);
      send({sc, hdr}, {pay, hdr}, chk_out);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        tbl [8];
      logic [65:0] blk;
      logic [63:0] sc;
      logic [1:0]  hdr;
      int          ptr, slips, gap;
      logic        locked;

      tbl[0] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      tbl[1] = '{2'b10, 64'h0123_4567_89AB_CDEF, 1'b1};
      tbl[2] = '{2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1};
      tbl[3] = '{2'b10, 64'h5555_5555_5555_5555, 1'b1};
      tbl[4] = '{2'b01, 64'h8000_0000_0000_0001, 1'b1};
      tbl[5] = '{2'b11, 64'hDEAD_BEEF_CAFE_F00D, 1'b1};
      tbl[6] = '{2'b10, 64'h0000_0000_0000_0000, 1'b1};
      tbl[7] = '{2'b01, 64'h0000_0000_0000_001E, 1'b1};

      rst_n      = 1'b0;
      data_i     = '0;
      data_vld_i = 1'b0;
`ifdef DESCRAMBLE_BER_MON_EN
      chk_ber = 1'b0;
`else
      chk_ber = 1'b1;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", data_o, 66'd0);
      chk1("rst_vld", data_vld_o, 1'b0);
      chk1("rst_lock", block_lock_o, 1'b0);
      chk1("rst_slip", slip_o, 1'b0);
      chk1("rst_ber", hi_ber_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Hand-computed vectors from a zero history.
      send({64'h0000_0000_0000_0001, 2'b01}, {64'h0400_0080_0000_0001, 2'b01}, 1'b1);
      send({64'h0000_0000_0000_0000, 2'b01}, {64'h0000_0000_0000_0000, 2'b01}, 1'b1);
      send({64'h8000_0000_0000_0000, 2'b10}, {64'h8000_0000_0000_0000, 2'b10}, 1'b1);
      send({64'h0000_0000_0000_0000, 2'b01}, {64'h0200_0040_0000_0000, 2'b01}, 1'b1);
      chk1("hand_no_lock", s_lock, 1'b0);

      // Loopback from seed 3: lock right after the 64th block.
      pulse_reset();
      tx_st = 58'h3;
      for (int n = 1; n <= 100; n++) begin
         send_lb(2'b01, 64'h0, n >= 2);
         chk1("lb_lock", s_lock, n >= 64);
         chk1("lb_slip", s_slip, 1'b0);
      end

      for (int i = 0; i < 8; i++) begin
         send_lb(tbl[i].hdr, tbl[i].pay, 1'b1);
         chk1("tbl_lock", s_lock, tbl[i].exp_lock);
         chk1("tbl_slip", s_slip, 1'b0);
      end
      for (int n = 0; n < 20; n++) send_lb(2'b01, 64'h0, 1'b1);

      // Window with 15 invalid headers keeps lock.
      for (int k = 0; k < 64; k++) begin
         hdr = ((k % 4 == 0) && (k < 60)) ? 2'b11 : 2'b01;
         send_lb(hdr, 64'h1234_0000_0000_5678 + 64'(k), 1'b1);
         chk1("inv15_lock", s_lock, 1'b1);
         chk1("inv15_slip", s_slip, 1'b0);
      end
      // 16 invalid headers: lock drops and slip pulses on the 16th.
      for (int k = 0; k < 16; k++) begin
         send_lb(2'b11, 64'h0, 1'b1);
         chk1("inv16_lock", s_lock, k < 15);
         chk1("inv16_slip", s_slip, k == 15);
      end

      // Headers ignored while waiting after a slip.
      for (int k = 0; k < 32; k++) begin
         send_lb(2'b11, 64'hFEED_0000_0000_0000 | 64'(k), 1'b1);
         chk1("wait_lock", s_lock, 1'b0);
         chk1("wait_slip", s_slip, 1'b0);
      end
      for (int k = 0; k < 64; k++) begin
         send_lb(2'b10, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
         chk1("relock", s_lock, k >= 63);
         chk1("relock_slip", s_slip, 1'b0);
      end
      for (int k = 0; k < 10; k++) send_lb(2'b01, 64'h0, 1'b1);
      chk1("pre_rst_lock", s_lock, 1'b1);

      // Asynchronous reset mid-window while locked.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_data", data_o, 66'd0);
      chk1("arst_vld", data_vld_o, 1'b0);
      chk1("arst_lock", block_lock_o, 1'b0);
      chk1("arst_slip", slip_o, 1'b0);
      chk1("arst_ber", hi_ber_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 64; k++) begin
         send_lb(2'b01, 64'h0, k >= 1);
         chk1("post_rst_lock", s_lock, k >= 63);
      end

      // Misaligned stream: 5 leading bits before the first block boundary.
      pulse_reset();
      tx_st = 58'h3;
      for (int j = 0; j < STREAM_BITS; j++) stream[j] = 1'b0;
      for (int k = 0; k < NB; k++) begin
         scramble(64'h0, sc);
         blk = {sc, 2'b01};
         for (int j = 0; j < 66; j++) stream[5 + 66 * k + j] = blk[j];
      end
      ptr    = 0;
      slips  = 0;
      gap    = 0;
      locked = 1'b0;
      for (int n = 0; (n < NB - 4) && !locked; n++) begin
         for (int j = 0; j < 66; j++) blk[j] = stream[ptr + j];
         ptr += 66;
         send(blk, 66'd0, 1'b0);
         gap++;
         if (s_slip) begin
            if (slips > 0) chk1("slip_spacing", gap >= int'(SLIP_WAIT), 1'b1);
            slips++;
            gap = 0;
            ptr++;
         end
         if (s_lock) locked = 1'b1;
      end
      chk1("gb_lock", locked, 1'b1);
      chk("gb_slips", 66'(slips), 66'd5);
      for (int n = 0; n < 2; n++) begin
         for (int j = 0; j < 66; j++) blk[j] = stream[ptr + j];
         ptr += 66;
         send(blk, {64'h0, 2'b01}, 1'b1);
         chk1("gb_hold_lock", s_lock, 1'b1);
         chk1("gb_no_slip", s_slip, 1'b0);
      end

`ifdef DESCRAMBLE_BER_MON_EN
      // 16 invalid headers in the first BER window, clean second window.
      pulse_reset();
      for (int n = 1; n <= 200; n++) begin
         hdr = (n <= 16) ? 2'b11 : 2'b01;
         send({64'h0, hdr}, 66'd0, 1'b0);
         chk1("hi_ber", s_ber, (n >= 16) && (n < 200));
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
